// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and helpers for the byte-enable single-port RAM
//
// Purpose: sequencer state encoding, read-during-write mode codes and the
//          lane-count helper used by ram_sp_be and ram_lane_array.
// Ports:   none (package).

package ram_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  function automatic int lane_count(input int n, input int lane);
    return n / lane;
  endfunction

endpackage

// File: rtl/ram_lane_array.sv
// rtl/ram_lane_array.sv - NL independent LANE-wide storage columns sharing one address
//
// Purpose: word storage split into byte-enable lanes; each lane has its own
//          write enable, all lanes share the address. Read is combinational
//          so the top level can register it and build the merged word.
// Ports:
//   clk    in   clock
//   we     in   NL   per-lane write enable
//   addr   in   AW   word address (caller keeps it < SZ when writing)
//   wdata  in   NL*LANE write data
//   rdata  out  NL*LANE current contents of the addressed word

module ram_lane_array #(
  parameter int SZ   = 32,
  parameter int AW   = 5,
  parameter int LANE = 8,
  parameter int NL   = 1
) (
  input  logic                 clk,
  input  logic [NL-1:0]        we,
  input  logic [AW-1:0]        addr,
  input  logic [NL*LANE-1:0]   wdata,
  output logic [NL*LANE-1:0]   rdata
);

  for (genvar k = 0; k < NL; k++) begin : g_lane
    logic [LANE-1:0] mem [SZ];

    always_ff @(posedge clk) begin
      if (we[k]) begin
        mem[addr] <= wdata[k*LANE +: LANE];
      end
    end

    assign rdata[k*LANE +: LANE] = mem[addr];
  end

endmodule

// File: rtl/ram_sp_be.sv
// rtl/ram_sp_be.sv - single-port synchronous RAM with byte enables and clear sequencer
//
// Purpose: one access per clock with a registered read and a read-valid strobe,
//          per-lane write enables, selectable read-during-write behaviour,
//          out-of-range detection and a zero-fill sweep after reset or on clr.
// Ports:
//   clk    in   clock, all logic on posedge
//   reset  in   asynchronous active-low reset
//   en     in   access request
//   rw     in   1 = write, 0 = read
//   iaddr  in   AW word address
//   i      in   N write data
//   be     in   N/LANE lane write enables
//   clr    in   request a zero-fill sweep
//   o      out  N registered read data
//   ovalid out  pulse: o updated for an accepted access
//   err    out  pulse: accepted access was out of range
//   busy   out  clear sweep in progress

module ram_sp_be
  import ram_pkg::*;
#(
  parameter int SZ         = 32,
  parameter int N          = 8,
  parameter int AW         = 5,
  parameter int LANE       = 8,
  parameter int RDW_MODE   = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              rw,
  input  logic [AW-1:0]     iaddr,
  input  logic [N-1:0]      i,
  input  logic [N/LANE-1:0] be,
  input  logic              clr,
  output logic [N-1:0]      o,
  output logic              ovalid,
  output logic              err,
  output logic              busy
);

  localparam int NL = lane_count(N, LANE);
  // One extra bit so SZ == 2**AW still compares correctly.
  localparam logic [AW:0]   SZ_EXT   = (AW + 1)'(SZ);
  localparam logic [AW-1:0] LAST_PTR = AW'(SZ - 1);
  localparam state_t        RST_STATE = (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

  state_t          state, state_nx;
  logic [AW-1:0]   ptr, ptr_nx;

  logic            in_range;
  logic            accept;
  logic [NL-1:0]   mem_we;
  logic [AW-1:0]   mem_addr;
  logic [N-1:0]    mem_wdata;
  logic [N-1:0]    mem_rdata;
  logic [N-1:0]    lane_mask;
  logic [N-1:0]    merged;

  assign in_range = ({1'b0, iaddr} < SZ_EXT);
  // clr always wins over a same-cycle access; nothing is accepted while sweeping.
  assign accept   = (state == ST_IDLE) && en && !clr;
  assign busy     = (state == ST_CLEAR);

  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < NL; k++) begin
      lane_mask[k*LANE +: LANE] = {LANE{be[k]}};
    end
  end

  assign merged = (i & lane_mask) | (mem_rdata & ~lane_mask);

  // Storage port: the sweep owns it in CLEAR, the user access in IDLE.
  always_comb begin
    mem_we    = '0;
    mem_addr  = iaddr;
    mem_wdata = i;
    if (state == ST_CLEAR) begin
      mem_we    = '1;
      mem_addr  = ptr;
      mem_wdata = '0;
    end else if (accept && rw && in_range) begin
      mem_we = be;
    end
  end

  ram_lane_array #(
    .SZ   (SZ),
    .AW   (AW),
    .LANE (LANE),
    .NL   (NL)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    case (state)
      ST_IDLE: begin
        if (clr) begin
          state_nx = ST_CLEAR;
          ptr_nx   = '0;
        end
      end
      ST_CLEAR: begin
        if (clr) begin
          ptr_nx = '0;
        end else if (ptr == LAST_PTR) begin
          state_nx = ST_IDLE;
          ptr_nx   = '0;
        end else begin
          ptr_nx = ptr + AW'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
        ptr_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RST_STATE;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o      <= '0;
      ovalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      ovalid <= accept;
      err    <= accept && !in_range;
      if (accept) begin
        if (!in_range) begin
          o <= '0;
        end else if (rw && (RDW_MODE == RDW_WRITE_FIRST)) begin
          o <= merged;
        end else begin
          // Combinational read before the edge is the pre-write word.
          o <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_sp_be.sv
// tb/tb_ram_sp_be.sv - self-checking bench for ram_sp_be
//
// Purpose: directed table vectors plus hand sequences for sweep, clr and reset.
// Ports:   none (top-level bench).

module tb_ram_sp_be;

  typedef struct {
    logic        en;
    logic        rw;
    logic        clr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp_o;
    logic        exp_ovalid;
    logic        exp_err;
    logic        exp_busy;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  logic       a_en, a_rw, a_clr;
  logic [4:0] a_addr;
  logic [7:0] a_i;
  logic [0:0] a_be;
  logic [7:0] a_o;
  logic       a_ovalid, a_err, a_busy;

  logic        b_en, b_rw, b_clr;
  logic [4:0]  b_addr;
  logic [31:0] b_i;
  logic [3:0]  b_be;
  logic [31:0] b_o;
  logic        b_ovalid, b_err, b_busy;

  int checks = 0;
  int errors = 0;

  vec_t va [9];
  vec_t vb [9];

  always #5 clk = ~clk;

  ram_sp_be #(
    .SZ(32), .N(8), .AW(5), .LANE(8), .RDW_MODE(0), .CLR_ON_RST(1)
  ) dut_a (
    .clk(clk), .reset(reset), .en(a_en), .rw(a_rw), .iaddr(a_addr),
    .i(a_i), .be(a_be), .clr(a_clr), .o(a_o), .ovalid(a_ovalid),
    .err(a_err), .busy(a_busy)
  );

  ram_sp_be #(
    .SZ(20), .N(32), .AW(5), .LANE(8), .RDW_MODE(1), .CLR_ON_RST(1)
  ) dut_b (
    .clk(clk), .reset(reset), .en(b_en), .rw(b_rw), .iaddr(b_addr),
    .i(b_i), .be(b_be), .clr(b_clr), .o(b_o), .ovalid(b_ovalid),
    .err(b_err), .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic en, input logic rw, input logic clr,
                         input logic [4:0] addr, input logic [7:0] data, input logic be);
    a_en = en; a_rw = rw; a_clr = clr; a_addr = addr; a_i = data; a_be = be;
  endtask

  task automatic apply_vec(input bit on_b, input vec_t v, input string name);
    if (on_b) begin
      b_en = v.en; b_rw = v.rw; b_clr = v.clr; b_addr = v.addr; b_i = v.data; b_be = v.be;
      tick();
      check(name, {29'd0, b_o, b_ovalid, b_err, b_busy},
            {29'd0, v.exp_o, v.exp_ovalid, v.exp_err, v.exp_busy});
    end else begin
      drive_a(v.en, v.rw, v.clr, v.addr, v.data[7:0], v.be[0]);
      tick();
      check(name, {53'd0, a_o, a_ovalid, a_err, a_busy},
            {53'd0, v.exp_o[7:0], v.exp_ovalid, v.exp_err, v.exp_busy});
    end
    b_en = 1'b0;
    drive_a(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
  endtask

  // Counts posedges until busy drops on dut_a; any ovalid meanwhile is flagged.
  task automatic wait_sweep_a(input string name, input int exp_cycles);
    int cnt = 0;
    int seen_valid = 0;
    while (a_busy && cnt < 40) begin
      tick();
      cnt++;
      if (a_ovalid) seen_valid++;
    end
    check({name, "_len"}, 64'(cnt), 64'(exp_cycles));
    check({name, "_no_ovalid"}, 64'(seen_valid), 64'd0);
  endtask

  initial begin
    //          en rw clr addr   data          be    exp_o         ov err busy
    va[0] = '{1'b1, 1'b1, 1'b0, 5'd5,  32'h12, 4'h1, 32'h00, 1'b1, 1'b0, 1'b0};
    va[1] = '{1'b1, 1'b1, 1'b0, 5'd5,  32'h34, 4'h1, 32'h12, 1'b1, 1'b0, 1'b0};
    va[2] = '{1'b1, 1'b0, 1'b0, 5'd5,  32'h00, 4'h0, 32'h34, 1'b1, 1'b0, 1'b0};
    va[3] = '{1'b0, 1'b0, 1'b0, 5'd9,  32'h00, 4'h0, 32'h34, 1'b0, 1'b0, 1'b0};
    va[4] = '{1'b1, 1'b1, 1'b0, 5'd6,  32'h77, 4'h0, 32'h00, 1'b1, 1'b0, 1'b0};
    va[5] = '{1'b1, 1'b0, 1'b0, 5'd6,  32'h00, 4'h0, 32'h00, 1'b1, 1'b0, 1'b0};
    va[6] = '{1'b1, 1'b1, 1'b0, 5'd31, 32'hC3, 4'h1, 32'h00, 1'b1, 1'b0, 1'b0};
    va[7] = '{1'b1, 1'b1, 1'b0, 5'd7,  32'h5A, 4'h1, 32'h00, 1'b1, 1'b0, 1'b0};
    va[8] = '{1'b1, 1'b0, 1'b0, 5'd7,  32'h00, 4'h0, 32'h5A, 1'b1, 1'b0, 1'b0};

    vb[0] = '{1'b1, 1'b1, 1'b0, 5'd3,  32'hAABBCCDD, 4'hF, 32'hAABBCCDD, 1'b1, 1'b0, 1'b0};
    vb[1] = '{1'b1, 1'b1, 1'b0, 5'd3,  32'h11223344, 4'h5, 32'hAA22CC44, 1'b1, 1'b0, 1'b0};
    vb[2] = '{1'b1, 1'b0, 1'b0, 5'd3,  32'h00000000, 4'h0, 32'hAA22CC44, 1'b1, 1'b0, 1'b0};
    vb[3] = '{1'b1, 1'b1, 1'b0, 5'd25, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vb[4] = '{1'b1, 1'b0, 1'b0, 5'd5,  32'h00000000, 4'h0, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vb[5] = '{1'b1, 1'b1, 1'b0, 5'd5,  32'h00000012, 4'h1, 32'h00000012, 1'b1, 1'b0, 1'b0};
    vb[6] = '{1'b1, 1'b1, 1'b0, 5'd5,  32'h00000034, 4'h1, 32'h00000034, 1'b1, 1'b0, 1'b0};
    vb[7] = '{1'b1, 1'b0, 1'b0, 5'd20, 32'h00000000, 4'h0, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vb[8] = '{1'b0, 1'b0, 1'b0, 5'd19, 32'h00000000, 4'h0, 32'h00000000, 1'b0, 1'b0, 1'b0};

    reset = 1'b0;
    drive_a(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    b_en = 1'b0; b_rw = 1'b0; b_clr = 1'b0; b_addr = 5'd0; b_i = 32'd0; b_be = 4'd0;
    tick();
    tick();
    check("reset_a", {53'd0, a_o, a_ovalid, a_err, a_busy}, {53'd0, 8'h00, 1'b0, 1'b0, 1'b1});
    check("reset_b", {29'd0, b_o, b_ovalid, b_err, b_busy}, {29'd0, 32'h0, 1'b0, 1'b0, 1'b1});

    // Sweep after reset release: exactly SZ posedges of busy.
    reset = 1'b1;
    wait_sweep_a("rst_sweep", 32);

    for (int k = 0; k < 32; k++) begin
      drive_a(1'b1, 1'b0, 1'b0, 5'(k), 8'h00, 1'b0);
      tick();
      check($sformatf("zero_rd_%0d", k), {53'd0, a_o, a_ovalid, a_err, a_busy},
            {53'd0, 8'h00, 1'b1, 1'b0, 1'b0});
    end

    for (int k = 0; k < 9; k++) apply_vec(1'b0, va[k], $sformatf("vec_a_%0d", k));

    // clr with a same-cycle read: read dropped, o holds, full sweep follows.
    drive_a(1'b1, 1'b0, 1'b1, 5'd7, 8'h00, 1'b0);
    tick();
    drive_a(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    check("clr_drop", {53'd0, a_o, a_ovalid, a_err, a_busy}, {53'd0, 8'h5A, 1'b0, 1'b0, 1'b1});
    wait_sweep_a("clr_sweep", 32);
    drive_a(1'b1, 1'b0, 1'b0, 5'd7, 8'h00, 1'b0);
    tick();
    check("clr_rd7", {53'd0, a_o, a_ovalid}, {53'd0, 8'h00, 1'b1});

    for (int k = 0; k < 9; k++) apply_vec(1'b1, vb[k], $sformatf("vec_b_%0d", k));

    // Reset in the middle of a sweep, with accesses attempted while busy.
    drive_a(1'b1, 1'b1, 1'b0, 5'd1, 8'h3C, 1'b1);
    tick();
    drive_a(1'b1, 1'b0, 1'b0, 5'd1, 8'h00, 1'b0);
    tick();
    check("pre_rst_rd1", {53'd0, a_o, a_ovalid}, {53'd0, 8'h3C, 1'b1});
    drive_a(1'b0, 1'b0, 1'b1, 5'd0, 8'h00, 1'b0);
    tick();
    a_clr = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    reset = 1'b0;
    #1;
    check("mid_rst", {53'd0, a_o, a_ovalid, a_err, a_busy}, {53'd0, 8'h00, 1'b0, 1'b0, 1'b1});
    tick();
    reset = 1'b1;
    drive_a(1'b1, 1'b1, 1'b0, 5'd2, 8'hFF, 1'b1);
    wait_sweep_a("mid_sweep", 32);
    drive_a(1'b1, 1'b0, 1'b0, 5'd2, 8'h00, 1'b0);
    tick();
    check("busy_no_write", {53'd0, a_o, a_ovalid}, {53'd0, 8'h00, 1'b1});
    drive_a(1'b1, 1'b0, 1'b0, 5'd1, 8'h00, 1'b0);
    tick();
    check("swept_rd1", {53'd0, a_o, a_ovalid}, {53'd0, 8'h00, 1'b1});
    drive_a(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    tick();
    check("idle_no_valid", {62'd0, a_ovalid, a_err}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_sp_be.md
Name: ram_sp_be

Overview:
Parametrised single-port synchronous RAM, next generation of the team's basic RAM block. Adds per-lane byte enables, a selectable read-during-write mode, out-of-range address detection and a hardware clear sequencer. The sequencer zero-fills the array after reset, or on request, and holds off accesses while busy. It is the general scratch/data memory for datapath blocks: one access per clock, with a read-valid strobe.

Parameters:
SZ, 32, number of words (1..2^AW)
N, 8, word width in bits; must be a multiple of LANE
AW, 5, address width; SZ <= 2^AW
LANE, 8, bits per byte-enable lane; NL = N/LANE lanes
RDW_MODE, 0, read-during-write: 0 = read-first (old data), 1 = write-first (merged new data)
CLR_ON_RST, 1, 1 = zero-fill sweep after reset release; 0 = no sweep, contents undefined

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  asynchronous, active-low reset
en  in  1  access request, sampled on posedge
rw  in  1  1 = write, 0 = read (qualified by en)
iaddr  in  AW  word address
i  in  N  write data
be  in  NL  lane write enables; lane k covers bits [k*LANE +: LANE]
clr  in  1  single-cycle request to zero-fill the array
o  out  N  read data, registered
ovalid  out  1  one-cycle pulse, o updated for an accepted access
err  out  1  one-cycle pulse, accepted access had iaddr >= SZ
busy  out  1  clear sweep in progress; accesses ignored

Behaviour:
- Reset asserted (reset=0), asynchronous:
  - o=0, ovalid=0, err=0, ptr=0.
  - State CLEAR with busy=1 if CLR_ON_RST=1; otherwise state IDLE with busy=0.
  - Array contents are not reset asynchronously.
- Reset mid-sweep: the sweep restarts from ptr=0 after release.
- FSM states: IDLE, CLEAR.
- CLEAR:
  - Each posedge writes 0 to data[ptr] across all lanes, then ptr++.
  - On the posedge that writes ptr==SZ-1: go to IDLE, ptr=0, busy=0 from that edge.
  - Sweep takes exactly SZ cycles; busy is high for SZ posedges after reset release.
  - en ignored: no write, o holds, ovalid=0, err=0.
  - clr=1 restarts the sweep at ptr=0.
- IDLE, clr=1: enter CLEAR at the next posedge, busy=1 from that edge. A same-cycle access is dropped (clr wins): no write, ovalid=0.
- IDLE, en=1, clr=0 (accepted access), latency 1:
  - ovalid=1 at the next posedge for both reads and writes.
  - Read (rw=0): o = data[iaddr].
  - Write (rw=1):
    - Only lanes with be[k]=1 are updated; be=0 is a legal no-write access.
    - RDW_MODE=0: o = pre-write word.
    - RDW_MODE=1: o = merged word (new lanes where be=1, old elsewhere).
- Out of range (iaddr >= SZ, accepted access): write suppressed, o=0, ovalid=1, err=1. Array unchanged; no wrap-around.
- en=0 in IDLE: o holds last value, ovalid=0, err=0.
- Back-to-back accesses: one per cycle, no bubbles. A read immediately after a write to the same address returns the written data.
- ovalid and err are never high for more than one cycle per accepted access.

Decomposition:
- Shared package ram_pkg holds:
  - state encodings ST_IDLE/ST_CLEAR
  - RDW_READ_FIRST=0, RDW_WRITE_FIRST=1
  - lane-count helper NL = N/LANE
- One natural sub-module, ram_lane_array: NL independent LANE-wide storage columns with per-lane write enable and a common address.
- Top level holds the FSM, sweep pointer, range check, RDW mux and output registers.

Test Plan:
1. Reset pulse, CLR_ON_RST=1, SZ=32 -> busy=1 for exactly 32 posedges after release; reading all 32 addresses then returns 0x00 with ovalid each cycle.
2. N=32, LANE=8: write 0xAABBCCDD be=1111 to addr 3, then 0x11223344 be=0101 -> read addr 3 returns 0xAA22CC44.
3. RDW_MODE=0 vs 1: addr 5 holds 0x12; write 0x34 be=1 -> o=0x12 (mode 0) / o=0x34 (mode 1), ovalid=1 one cycle later.
4. SZ=20, AW=5: write 0xFF to iaddr 25 -> err=1, ovalid=1, o=0; read addr 5 (25 mod 20) still returns 0x00.
5. Write 0x5A to addr 7; assert clr together with en/read addr 7 -> no ovalid, busy=1 for 32 cycles; then read addr 7 -> 0x00.
6. Assert reset mid-sweep at ptr=10 -> outputs 0 immediately; after release busy lasts a full 32 cycles; en during busy yields no ovalid and no write.
